// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of register_file: round-robin between ALU and load
// unit, one registered write per cycle, plus a pending-register scoreboard for hazards.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        hazard,
    output logic        regWrite,
    output logic [4:0]  regd,
    output logic [31:0] dataWrite,
    output logic        idle
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t      last_grant;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        alu_win;
    logic        mem_win;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (alu_valid && mem_valid) begin
            alu_win = (last_grant == GRANT_MEM);
            mem_win = (last_grant == GRANT_ALU);
        end else begin
            alu_win = alu_valid;
            mem_win = mem_valid;
        end
    end

    assign alu_ready = alu_win;
    assign mem_ready = mem_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_MEM;
            regWrite   <= 1'b0;
            regd       <= 5'd0;
            dataWrite  <= 32'd0;
        end else if (alu_win) begin
            last_grant <= GRANT_ALU;
            regWrite   <= 1'b1;
            regd       <= alu_rd;
            dataWrite  <= alu_data;
        end else if (mem_win) begin
            last_grant <= GRANT_MEM;
            regWrite   <= 1'b1;
            regd       <= mem_rd;
            dataWrite  <= mem_data;
        end else begin
            regWrite   <= 1'b0;
        end
    end

    assign issue_ready = ~pending[issue_rd];

    // The set is applied after the clear so a same-register collision keeps the bit.
    always_comb begin
        pending_next = pending;
        if (regWrite) begin
            pending_next[regd] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            pending_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard = pending[rs] | pending[rt];
    assign idle   = (pending == 32'd0) && !regWrite;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock, with an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock shared with register_file.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 alu_valid / alu_rd / alu_data  in  1/5/32  ALU writeback request, destination, result.
REQ-005 alu_ready  out  1  ALU request accepted this cycle.
REQ-006 mem_valid / mem_rd / mem_data  in  1/5/32  load-unit writeback request, destination, data.
REQ-007 mem_ready  out  1  load request accepted this cycle.
REQ-008 issue_valid / issue_rd  in  1/5  decode marks issue_rd as pending a writeback.
REQ-009 issue_ready  out  1  issue accepted, i.e. issue_rd is not already pending.
REQ-010 rs / rt  in  5/5  source registers of the instruction in decode.
REQ-011 hazard  out  1  rs or rt is pending.
REQ-012 regWrite / regd / dataWrite  out  1/5/32  registered write port into register_file.
REQ-013 idle  out  1  no register is pending and regWrite is 0.

Function
REQ-014 The block SHALL accept at most one writeback per cycle; a transfer occurs when valid and ready are both 1 on a rising edge.
REQ-015 alu_ready and mem_ready SHALL be combinational from the valid inputs and last_grant, and SHALL never both be 1.
REQ-016 Single request: the block SHALL grant the only valid requester.
REQ-017 Both requesters valid: the block SHALL grant the requester that is not last_grant (round-robin); last_grant SHALL update only on a transfer.
REQ-018 A requester held valid while not granted SHALL keep its rd/data stable; the block SHALL not drop or reorder that request.
REQ-019 On a transfer, the block SHALL set regWrite=1 with regd/dataWrite equal to the granted rd/data on the next edge (latency 1 cycle).
REQ-020 With no transfer, regWrite SHALL be 0 on the next edge, and regd/dataWrite SHALL hold their values.
REQ-021 The scoreboard SHALL be a 32-bit pending vector, one bit per register (r0 included, no special case).
REQ-022 issue_ready = ~pending[issue_rd]; when issue_valid and issue_ready are 1, the block SHALL set pending[issue_rd] on the edge.
REQ-023 On an edge where regWrite=1, the block SHALL clear pending[regd], so the bit drops the cycle after register_file has written the value.
REQ-024 If a set and a clear target the same register on the same edge, set SHALL win.
REQ-025 hazard = pending[rs] | pending[rt], combinational.
REQ-026 A writeback to a non-pending register SHALL still be written, and the clear SHALL be a no-op.
REQ-027 idle SHALL be combinational: (pending == 0) and regWrite == 0.

Reset
REQ-028 rst_n low SHALL immediately force pending=0, regWrite=0, regd=0, dataWrite=0, and last_grant=MEM, so the ALU wins the first contention.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight writes and pending bits; no regWrite pulse SHALL follow deassertion without a new transfer.
REQ-030 The first transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-031 Issue rd=5, then ALU writes rd=5 data=0xDEADBEEF -> issue accepted, hazard=1 for rs=5, regWrite=1/regd=5 one cycle after transfer, hazard=0 the following cycle.
REQ-032 ALU rd=3 and MEM rd=4 valid together for 2 cycles after reset -> cycle 1 alu_ready=1, cycle 2 mem_ready=1, regd sequence 3 then 4.
REQ-033 Issue rd=7 twice back-to-back -> second cycle issue_ready=0, pending[7] set once.
REQ-034 regWrite=1 for regd=9 with issue rd=9 on the same edge -> pending[9] remains 1, hazard=1 for rt=9.
REQ-035 rst_n pulsed low while regWrite=1 and pending=0x0000_0030 -> outputs 0 asynchronously, idle=1, no write after release.
REQ-036 Continuous ALU+MEM contention for 8 cycles -> grants alternate exactly 4/4, never both ready in the same cycle.
